cbfp_frame_sequencer: RTL and testbench

- Frame-level controller for the CBFP normalisation stage.
- Accepts 16-sample batches from the upstream FFT butterfly stage and issues them to the CBFP datapath as `in_valid` strobes.
- Tracks batches in flight against the datapath's fixed latency, matches returned `valid_out` beats to batch indices, and reports frame boundaries.
- Gates issue with a credit counter so the downstream output buffer never overflows; the CBFP datapath itself cannot stall.

---
 rtl/cbfp_frame_sequencer.sv | 214 +++++++++++++++++++++
 tb/tb_cbfp_frame_sequencer.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cbfp_frame_sequencer.sv
// cbfp_frame_sequencer
//   Frame-level controller for the CBFP normalisation stage. Issues 16-sample
//   batches from the FFT butterfly stage to the fixed-latency CBFP datapath,
//   tracks returned result beats against batch indices, reports frame
//   boundaries and gates issue with a downstream-buffer credit counter.
//
// Parameters
//   BATCHES_PER_FRAME  batches per frame (512 points / 16 = 32)
//   CREDITS            downstream buffer capacity in batches (<= 63)
//   TIMEOUT            quiet cycles in DRAIN before err_timeout fires
//
// Ports
//   clk, rst         single clock, synchronous active-high reset
//   up_valid/ready   upstream batch handshake (ready is combinational)
//   cbfp_in_valid    issue strobe to the datapath (up_valid && up_ready)
//   cbfp_valid_out   result beat from the datapath
//   ds_pop           downstream consumed one batch (returns a credit)
//   batch_idx_in     index of the batch being issued
//   batch_idx_out    index of the current result beat
//   frame_start      pulse on the first issue of a frame
//   frame_done       high for the single cycle after the last result beat
//   busy             sequencer is not idle
//   credit_cnt       credits currently available
//   err_timeout, err_spurious, err_credit   sticky error flags
//   err_clr          clears the sticky error flags (a same-cycle set wins)
//
// Build option
//   CBFP_SEQ_ERRCHK_EN  enables the DRAIN timeout and the three error flags;
//                       without it the flags read 0 and DRAIN waits forever.

module cbfp_frame_sequencer #(
  parameter int unsigned BATCHES_PER_FRAME = 32,
  parameter int unsigned CREDITS           = 32,
  parameter int unsigned TIMEOUT           = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       up_valid,
  output logic       up_ready,
  output logic       cbfp_in_valid,
  input  logic       cbfp_valid_out,
  input  logic       ds_pop,
  output logic [4:0] batch_idx_in,
  output logic [4:0] batch_idx_out,
  output logic       frame_start,
  output logic       frame_done,
  output logic       busy,
  output logic [5:0] credit_cnt,
  output logic       err_timeout,
  output logic       err_spurious,
  output logic       err_credit,
  input  logic       err_clr
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FILL,
    S_DRAIN,
    S_DONE
  } state_t;

  localparam logic [4:0] LAST_IDX = 5'(BATCHES_PER_FRAME - 1);
  localparam logic [5:0] CRED_MAX = 6'(CREDITS);

  state_t     r_state;
  state_t     w_state_nxt;
  logic [4:0] r_in_cnt;
  logic [4:0] r_out_cnt;
  logic [5:0] r_credit;

  logic w_accept;
  logic w_beat;
  logic w_last_in;
  logic w_last_out;
  logic w_timeout_done;

  assign w_accept   = up_valid && up_ready;
  // Beats are only meaningful while a frame is open; in IDLE/DONE they are dropped.
  assign w_beat     = cbfp_valid_out && ((r_state == S_FILL) || (r_state == S_DRAIN));
  assign w_last_in  = w_accept && (r_in_cnt == LAST_IDX);
  assign w_last_out = w_beat && (r_state == S_DRAIN) && (r_out_cnt == LAST_IDX);

  assign cbfp_in_valid = w_accept;
  assign batch_idx_in  = r_in_cnt;
  assign batch_idx_out = r_out_cnt;
  assign credit_cnt    = r_credit;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    up_ready    = 1'b0;
    frame_start = 1'b0;
    frame_done  = 1'b0;
    busy        = 1'b1;
    case (r_state)
      S_IDLE: begin
        up_ready    = (r_credit != '0);
        frame_start = up_valid && (r_credit != '0);
        busy        = 1'b0;
        if (w_accept) begin
          w_state_nxt = w_last_in ? S_DRAIN : S_FILL;
        end
      end
      S_FILL: begin
        up_ready = (r_credit != '0);
        if (w_last_in) begin
          w_state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (w_last_out || w_timeout_done) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        frame_done  = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_in_cnt <= '0;
    end else if (w_accept) begin
      r_in_cnt <= w_last_in ? '0 : r_in_cnt + 1'b1;
    end
  end

  // Cleared in DONE as well so a timed-out frame does not leak its partial count.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_cnt <= '0;
    end else if (r_state == S_DONE) begin
      r_out_cnt <= '0;
    end else if (w_beat) begin
      r_out_cnt <= (r_out_cnt == LAST_IDX) ? '0 : r_out_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_credit <= CRED_MAX;
    end else if (w_accept && !ds_pop) begin
      r_credit <= r_credit - 1'b1;
    end else if (!w_accept && ds_pop && (r_credit != CRED_MAX)) begin
      r_credit <= r_credit + 1'b1;
    end
  end

`ifdef CBFP_SEQ_ERRCHK_EN
  localparam int unsigned   TW     = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TO_LIM = TW'(TIMEOUT);
  localparam logic [TW-1:0] TO_PRE = TW'(TIMEOUT - 1);

  logic [TW-1:0] r_to_cnt;
  logic [TW-1:0] w_to_base;
  logic          r_err_timeout;
  logic          r_err_spurious;
  logic          r_err_credit;
  logic          w_set_timeout;
  logic          w_set_spurious;
  logic          w_set_credit;

  // A beat restarts the count in its own cycle, so r_to_cnt equals the number
  // of cycles since the latest beat (or since DRAIN was entered).
  assign w_to_base      = cbfp_valid_out ? '0 : r_to_cnt;
  assign w_set_timeout  = (r_state == S_DRAIN) && (w_to_base == TO_PRE);
  assign w_timeout_done = (r_state == S_DRAIN) && (r_to_cnt == TO_LIM);
  assign w_set_spurious = cbfp_valid_out && ((r_state == S_IDLE) || (r_state == S_DONE));
  assign w_set_credit   = ds_pop && !w_accept && (r_credit == CRED_MAX);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_to_cnt       <= '0;
      r_err_timeout  <= 1'b0;
      r_err_spurious <= 1'b0;
      r_err_credit   <= 1'b0;
    end else begin
      if (r_state != S_DRAIN) begin
        r_to_cnt <= '0;
      end else if (w_to_base != TO_LIM) begin
        r_to_cnt <= w_to_base + 1'b1;
      end
      r_err_timeout  <= w_set_timeout  || (r_err_timeout  && !err_clr);
      r_err_spurious <= w_set_spurious || (r_err_spurious && !err_clr);
      r_err_credit   <= w_set_credit   || (r_err_credit   && !err_clr);
    end
  end

  assign err_timeout  = r_err_timeout;
  assign err_spurious = r_err_spurious;
  assign err_credit   = r_err_credit;
`else
  logic w_unused_errchk;

  assign w_timeout_done  = 1'b0;
  assign err_timeout     = 1'b0;
  assign err_spurious    = 1'b0;
  assign err_credit      = 1'b0;
  assign w_unused_errchk = err_clr ^ (TIMEOUT == 0);
`endif

endmodule

// File: tb/tb_cbfp_frame_sequencer.sv
// Bench for cbfp_frame_sequencer: a latency-programmable datapath stand-in and
// a count-based frame model (issued / returned / credits / time since last
// activity) predict every output each cycle; directed phases add cycle-exact
// checks for frame timing, credit exhaustion, timeout and mid-frame reset.

module tb_cbfp_frame_sequencer;

  localparam int BPF  = 32;
  localparam int CRED = 4;
  localparam int TMO  = 64;

`ifdef CBFP_SEQ_ERRCHK_EN
  localparam bit ERRCHK = 1'b1;
`else
  localparam bit ERRCHK = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       up_valid;
  logic       up_ready;
  logic       cbfp_in_valid;
  logic       cbfp_valid_out;
  logic       ds_pop;
  logic [4:0] batch_idx_in;
  logic [4:0] batch_idx_out;
  logic       frame_start;
  logic       frame_done;
  logic       busy;
  logic [5:0] credit_cnt;
  logic       err_timeout;
  logic       err_spurious;
  logic       err_credit;
  logic       err_clr;

  always #5 clk = ~clk;

  cbfp_frame_sequencer #(
    .BATCHES_PER_FRAME(BPF),
    .CREDITS          (CRED),
    .TIMEOUT          (TMO)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .up_valid      (up_valid),
    .up_ready      (up_ready),
    .cbfp_in_valid (cbfp_in_valid),
    .cbfp_valid_out(cbfp_valid_out),
    .ds_pop        (ds_pop),
    .batch_idx_in  (batch_idx_in),
    .batch_idx_out (batch_idx_out),
    .frame_start   (frame_start),
    .frame_done    (frame_done),
    .busy          (busy),
    .credit_cnt    (credit_cnt),
    .err_timeout   (err_timeout),
    .err_spurious  (err_spurious),
    .err_credit    (err_credit),
    .err_clr       (err_clr)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // frame model
  int m_issued   = 0;
  int m_returned = 0;
  int m_credits  = CRED;
  int m_ref      = 0;
  bit m_done     = 1'b0;
  bit m_et       = 1'b0;
  bit m_es       = 1'b0;
  bit m_ec       = 1'b0;

  // datapath stand-in
  int due_q[$];
  int lat       = 5;
  bit drop_last = 1'b0;
  bit inj_vo    = 1'b0;

  // observations
  int cyc      = 0;
  int n_acc    = 0;
  int fs_cyc   = -1;
  int done_cyc = -1;
  int busy_cyc = -1;
  int b30_cyc  = -1;
  int t0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0d, expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic tick();
    bit vo, rdy, acc, drain, counted, tmo_set, tmo_force;
    vo = inj_vo;
    if (due_q.size() != 0 && due_q[0] == cyc) begin
      void'(due_q.pop_front());
      vo = 1'b1;
    end
    cbfp_valid_out = vo;
    #1;
    rdy = !m_done && (m_issued < BPF) && (m_credits > 0);
    acc = up_valid && rdy;
    if (!rst) begin
      check_eq("up_ready",      up_ready,      rdy);
      check_eq("cbfp_in_valid", cbfp_in_valid, acc);
      check_eq("batch_idx_in",  batch_idx_in,  m_issued % BPF);
      check_eq("batch_idx_out", batch_idx_out, m_returned % BPF);
      check_eq("frame_start",   frame_start,   acc && (m_issued == 0));
      check_eq("frame_done",    frame_done,    m_done);
      check_eq("busy",          busy,          (m_issued != 0) || m_done);
      check_eq("credit_cnt",    credit_cnt,    m_credits);
      check_eq("err_timeout",   err_timeout,   m_et);
      check_eq("err_spurious",  err_spurious,  m_es);
      check_eq("err_credit",    err_credit,    m_ec);
      if (cbfp_in_valid) n_acc++;
      if (frame_start)   fs_cyc   = cyc;
      if (frame_done)    done_cyc = cyc;
      if (busy)          busy_cyc = cyc;
    end

    if (rst) begin
      m_issued   = 0;
      m_returned = 0;
      m_credits  = CRED;
      m_ref      = 0;
      m_done     = 1'b0;
      m_et       = 1'b0;
      m_es       = 1'b0;
      m_ec       = 1'b0;
      due_q.delete();
    end else begin
      drain     = (m_issued == BPF) && !m_done;
      counted   = vo && (m_issued != 0) && !m_done;
      tmo_set   = ERRCHK && drain && !vo && (cyc + 1 - m_ref == TMO);
      tmo_force = ERRCHK && drain && (cyc - m_ref == TMO);
      m_et = (m_et && !err_clr) || tmo_set;
      m_es = (m_es && !err_clr) || (ERRCHK && vo && !counted);
      m_ec = (m_ec && !err_clr) || (ERRCHK && ds_pop && !acc && (m_credits == CRED));
      if (acc && !ds_pop) m_credits--;
      else if (!acc && ds_pop && m_credits < CRED) m_credits++;
      if (m_done) begin
        m_done     = 1'b0;
        m_issued   = 0;
        m_returned = 0;
      end else begin
        if (acc) begin
          if (!(drop_last && m_issued == BPF - 1)) due_q.push_back(cyc + lat);
          m_issued++;
          if (m_issued == BPF) m_ref = cyc + 1;
        end
        if (counted) begin
          if (m_returned == BPF - 2) b30_cyc = cyc;
          m_returned++;
          if (drain) m_ref = cyc;
          if (m_returned == BPF) m_done = 1'b1;
        end
        if (tmo_force) m_done = 1'b1;
      end
    end

    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run_until_idle(input int bound);
    for (int i = 0; i < bound && busy !== 1'b0; i++) tick();
    check_eq("idle_bound", busy, 1'b0);
  endtask

  task automatic issue_frame(input int bound, input bit rnd);
    for (int i = 0; i < bound && m_issued < BPF; i++) begin
      if (rnd) begin
        up_valid = ($urandom_range(0, 9) < 7);
        ds_pop   = $urandom_range(0, 1);
        err_clr  = ($urandom_range(0, 15) == 0);
      end else begin
        up_valid = 1'b1;
      end
      tick();
    end
    up_valid = 1'b0;
    err_clr  = 1'b0;
  endtask

  initial begin
    rst = 1'b1; up_valid = 1'b0; ds_pop = 1'b0; err_clr = 1'b0; cbfp_valid_out = 1'b0;
    @(posedge clk);
    #1;
    tick();
    tick();
    rst = 1'b0;
    tick();
    tick();

    // full frame, latency 5, pop every cycle
    lat = 5; ds_pop = 1'b1; t0 = cyc;
    issue_frame(32, 1'b0);
    run_until_idle(100);
    check_eq("t1_frame_start_cycle", fs_cyc - t0, 0);
    check_eq("t1_frame_done_cycle",  done_cyc - t0, 37);
    check_eq("t1_busy_low_cycle",    busy_cyc + 1 - t0, 38);
    check_eq("t1_credit_const",      credit_cnt, CRED);
    check_eq("t1_err_credit",        err_credit, ERRCHK);
    err_clr = 1'b1;
    tick();
    check_eq("set_wins_err_credit",  err_credit, ERRCHK);
    ds_pop = 1'b0;
    tick();
    err_clr = 1'b0;
    check_eq("clr_err_credit",       err_credit, 1'b0);

    // credit exhaustion
    up_valid = 1'b1; n_acc = 0;
    repeat (10) tick();
    check_eq("t2_accepts",   n_acc, 4);
    check_eq("t2_credit",    credit_cnt, 0);
    check_eq("t2_not_ready", up_ready, 1'b0);
    ds_pop = 1'b1;
    tick();
    ds_pop = 1'b0; n_acc = 0;
    repeat (5) tick();
    check_eq("t2_one_more", n_acc, 1);
    ds_pop = 1'b1;
    issue_frame(200, 1'b0);
    run_until_idle(100);

    // randomized frames
    for (int f = 0; f < 6; f++) begin
      lat = $urandom_range(1, 8);
      issue_frame(400, 1'b1);
      ds_pop = 1'b1;
      run_until_idle(100);
    end

    // final beat dropped
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0; drop_last = 1'b1; lat = 5; ds_pop = 1'b1; b30_cyc = -1;
    issue_frame(32, 1'b0);
    for (int i = 0; i < 100 && b30_cyc < 0; i++) tick();
    for (int i = 0; i < 100 && cyc < b30_cyc + TMO - 1; i++) tick();
    check_eq("tmo_before",     err_timeout, 1'b0);
    tick();
    check_eq("tmo_flag",       err_timeout, ERRCHK);
    check_eq("tmo_done_early", frame_done, 1'b0);
    tick();
    check_eq("tmo_frame_done", frame_done, ERRCHK);
    tick();
    check_eq("tmo_idle",       busy, !ERRCHK);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    tick();
    check_eq("tmo_clr",        err_timeout, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0; drop_last = 1'b0;

    // reset mid-frame
    lat = 4; ds_pop = 1'b1; up_valid = 1'b1;
    repeat (10) tick();
    rst = 1'b1; up_valid = 1'b0;
    tick();
    rst = 1'b0;
    check_eq("rst_credit",    credit_cnt, CRED);
    check_eq("rst_busy",      busy, 1'b0);
    check_eq("rst_idx_in",    batch_idx_in, 0);
    check_eq("rst_idx_out",   batch_idx_out, 0);
    done_cyc = -1;
    issue_frame(32, 1'b0);
    run_until_idle(100);
    check_eq("rst_frame_done_seen", done_cyc > 0, 1'b1);
    ds_pop = 1'b0; inj_vo = 1'b1;
    tick();
    inj_vo = 1'b0;
    tick();
    check_eq("spurious_flag", err_spurious, ERRCHK);
    check_eq("spurious_idle", busy, 1'b0);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach the summary");
    $fatal(1);
  end

endmodule
